wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/mips_16_defs.sv | 20 ++
 rtl/wb_arbiter_if.sv | 50 +++++
 rtl/wb_result_fifo.sv | 87 ++++++++
 rtl/wb_arbiter.sv | 74 +++++++
 tb/tb_wb_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mips_16_defs.sv
// Shared register-file geometry for the mips_16 core.
package mips_16_defs;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int REG_COUNT  = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  localparam reg_addr_t ZERO_REG = 3'd0;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input reg_addr_t addr);
    logic [REG_COUNT-1:0] v;
    v = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the pipeline, the long-latency unit and the register file.
// The pend_mask signal exists only when WB_PEND_MASK_EN is defined.
interface wb_arbiter_if;
  import mips_16_defs::*;

  logic      wb_write_en;
  reg_addr_t wb_write_dest;
  reg_data_t wb_write_data;
  logic      lu_valid;
  reg_addr_t lu_dest;
  reg_data_t lu_data;
  logic      lu_ready;
  logic      reg_write_en;
  reg_addr_t reg_write_dest;
  reg_data_t reg_write_data;
`ifdef WB_PEND_MASK_EN
  logic [REG_COUNT-1:0] pend_mask;

  modport slave (
    input  wb_write_en, wb_write_dest, wb_write_data,
    input  lu_valid, lu_dest, lu_data,
    output lu_ready,
    output reg_write_en, reg_write_dest, reg_write_data,
    output pend_mask
  );

  modport master (
    output wb_write_en, wb_write_dest, wb_write_data,
    output lu_valid, lu_dest, lu_data,
    input  lu_ready,
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  pend_mask
  );
`else
  modport slave (
    input  wb_write_en, wb_write_dest, wb_write_data,
    input  lu_valid, lu_dest, lu_data,
    output lu_ready,
    output reg_write_en, reg_write_dest, reg_write_data
  );

  modport master (
    output wb_write_en, wb_write_dest, wb_write_data,
    output lu_valid, lu_dest, lu_data,
    input  lu_ready,
    input  reg_write_en, reg_write_dest, reg_write_data
  );
`endif

endinterface

// File: rtl/wb_result_fifo.sv
// In-order queue of long-latency results with squash-by-destination.
// With WB_PEND_MASK_EN defined it also decodes the pending-destination mask.
module wb_result_fifo
  import mips_16_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  reg_addr_t              push_dest,
  input  reg_data_t              push_data,
  input  logic                   pop,
  input  logic                   squash,
  input  reg_addr_t              squash_dest,
  output logic                   head_valid,
  output reg_addr_t              head_dest,
  output reg_data_t              head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef WB_PEND_MASK_EN
  ,
  output logic [REG_COUNT-1:0]   pend_mask
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic      ent_valid [DEPTH];
  reg_addr_t ent_dest  [DEPTH];
  reg_data_t ent_data  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pop clears the head slot; push never targets the head unless the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_dest[i]  <= ZERO_REG;
        ent_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && ent_valid[i] && (ent_dest[i] == squash_dest))
          ent_valid[i] <= 1'b0;
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_dest[wr_ptr]  <= push_dest;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = ent_valid[rd_ptr];
  assign head_dest  = ent_dest[rd_ptr];
  assign head_data  = ent_data[rd_ptr];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

`ifdef WB_PEND_MASK_EN
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i])
        pend_mask = pend_mask | reg_onehot(ent_dest[i]);
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline write-back and queued long-latency results onto one register-file port.
// Define WB_PEND_MASK_EN to export the pending-destination mask.
module wb_arbiter
  import mips_16_defs::*;
#(
  parameter int LU_DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  logic      eff_wb;
  logic      push;
  logic      pop;
  logic      drain_write;
  logic      fifo_head_valid;
  reg_addr_t fifo_head_dest;
  reg_data_t fifo_head_data;
  logic      fifo_full;
  logic      fifo_empty;
  logic [$clog2(LU_DEPTH):0] fifo_count;
  logic      unused_count;

  assign eff_wb = bus.wb_write_en && (bus.wb_write_dest != ZERO_REG);

  // A same-cycle pipeline write to the same register is younger, so the lu result is dropped.
  assign push = bus.lu_valid && bus.lu_ready && (bus.lu_dest != ZERO_REG)
             && !(eff_wb && (bus.lu_dest == bus.wb_write_dest));

  assign pop         = !fifo_empty && !eff_wb;
  assign drain_write = pop && fifo_head_valid;
  assign bus.lu_ready = !fifo_full;
  assign unused_count = ^fifo_count;

  wb_result_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_dest   (bus.lu_dest),
    .push_data   (bus.lu_data),
    .pop         (pop),
    .squash      (eff_wb),
    .squash_dest (bus.wb_write_dest),
    .head_valid  (fifo_head_valid),
    .head_dest   (fifo_head_dest),
    .head_data   (fifo_head_data),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
`ifdef WB_PEND_MASK_EN
    ,
    .pend_mask   (bus.pend_mask)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.reg_write_en   <= 1'b0;
      bus.reg_write_dest <= ZERO_REG;
      bus.reg_write_data <= '0;
    end else begin
      bus.reg_write_en <= eff_wb || drain_write;
      if (eff_wb) begin
        bus.reg_write_dest <= bus.wb_write_dest;
        bus.reg_write_data <= bus.wb_write_data;
      end else if (drain_write) begin
        bus.reg_write_dest <= fifo_head_dest;
        bus.reg_write_data <= fifo_head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expected write sequences.
module tb_wb_arbiter;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;

  wb_arbiter_if bus ();

  wb_arbiter #(.LU_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] dest, input logic [15:0] data);
    bus.wb_write_en   = en;
    bus.wb_write_dest = dest;
    bus.wb_write_data = data;
  endtask

  task automatic set_lu(input logic vld, input logic [2:0] dest, input logic [15:0] data);
    bus.lu_valid = vld;
    bus.lu_dest  = dest;
    bus.lu_data  = data;
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] dest, input logic [15:0] data);
    chk({tag, "_en"},   32'(bus.reg_write_en), 32'd1);
    chk({tag, "_dest"}, 32'(bus.reg_write_dest), 32'(dest));
    chk({tag, "_data"}, 32'(bus.reg_write_data), 32'(data));
  endtask

  task automatic chk_pend(input string tag, input logic [7:0] exp);
`ifdef WB_PEND_MASK_EN
    chk(tag, 32'(bus.pend_mask), 32'(exp));
`else
    if (exp != exp) $display("unreachable %s", tag);
`endif
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst_n = 1'b0;
    set_wb(1'b0, 3'd0, 16'h0);
    set_lu(1'b0, 3'd0, 16'h0);
    #12;
    chk("rst_en",    32'(bus.reg_write_en), 32'd0);
    chk("rst_dest",  32'(bus.reg_write_dest), 32'd0);
    chk("rst_data",  32'(bus.reg_write_data), 32'd0);
    chk("rst_ready", 32'(bus.lu_ready), 32'd1);
    chk_pend("rst_pend", 8'h00);
    rst_n = 1'b1;

    // pipeline only, then hold when idle
    set_wb(1'b1, 3'd3, 16'h1234);
    tick();
    chk_wr("pipe", 3'd3, 16'h1234);
    set_wb(1'b0, 3'd0, 16'h0);
    tick();
    chk("hold_en",   32'(bus.reg_write_en), 32'd0);
    chk("hold_dest", 32'(bus.reg_write_dest), 32'd3);
    chk("hold_data", 32'(bus.reg_write_data), 32'h1234);

    // contention: lu r5 waits behind three pipeline writes to r2
    set_wb(1'b1, 3'd2, 16'h0A00);
    set_lu(1'b1, 3'd5, 16'hBEEF);
    tick();
    set_lu(1'b0, 3'd0, 16'h0);
    chk_wr("cont_p0", 3'd2, 16'h0A00);
    chk_pend("cont_pend", 8'h20);
    set_wb(1'b1, 3'd2, 16'h0A01);
    tick();
    chk_wr("cont_p1", 3'd2, 16'h0A01);
    set_wb(1'b1, 3'd2, 16'h0A02);
    tick();
    chk_wr("cont_p2", 3'd2, 16'h0A02);
    set_wb(1'b0, 3'd0, 16'h0);
    tick();
    chk_wr("cont_lu", 3'd5, 16'hBEEF);
    tick();
    chk("cont_idle", 32'(bus.reg_write_en), 32'd0);
    chk_pend("cont_pend_clr", 8'h00);

    // full queue: r4, r6 accepted, r7 held until a slot frees
    set_wb(1'b1, 3'd1, 16'h0101);
    set_lu(1'b1, 3'd4, 16'h4444);
    tick();
    chk("full_rdy1", 32'(bus.lu_ready), 32'd1);
    set_lu(1'b1, 3'd6, 16'h6666);
    tick();
    chk("full_rdy0", 32'(bus.lu_ready), 32'd0);
    set_lu(1'b1, 3'd7, 16'h7777);
    tick();
    chk_wr("full_pipe", 3'd1, 16'h0101);
    chk("full_held", 32'(bus.lu_ready), 32'd0);
    set_wb(1'b0, 3'd0, 16'h0);
    tick();
    chk_wr("full_r4", 3'd4, 16'h4444);
    chk("full_rdy_again", 32'(bus.lu_ready), 32'd1);
    tick();
    set_lu(1'b0, 3'd0, 16'h0);
    chk_wr("full_r6", 3'd6, 16'h6666);
    tick();
    chk_wr("full_r7", 3'd7, 16'h7777);
    tick();
    chk("full_idle", 32'(bus.reg_write_en), 32'd0);

    // squash: queued r4=0001 overtaken by pipeline r4=0002
    set_wb(1'b1, 3'd1, 16'h0111);
    set_lu(1'b1, 3'd4, 16'h0001);
    tick();
    set_lu(1'b0, 3'd0, 16'h0);
    chk_pend("sq_pend_set", 8'h10);
    set_wb(1'b1, 3'd4, 16'h0002);
    tick();
    chk_wr("sq_pipe", 3'd4, 16'h0002);
    chk_pend("sq_pend_clr", 8'h00);
    set_wb(1'b0, 3'd0, 16'h0);
    tick();
    chk("sq_no_write", 32'(bus.reg_write_en), 32'd0);
    chk("sq_data_kept", 32'(bus.reg_write_data), 32'h0002);
    tick();
    chk("sq_ready", 32'(bus.lu_ready), 32'd1);

    // same-cycle lu and pipeline to r5: lu result dropped
    set_wb(1'b1, 3'd5, 16'h5555);
    set_lu(1'b1, 3'd5, 16'hDEAD);
    tick();
    set_wb(1'b0, 3'd0, 16'h0);
    set_lu(1'b0, 3'd0, 16'h0);
    chk_wr("same_pipe", 3'd5, 16'h5555);
    tick();
    chk("same_drop", 32'(bus.reg_write_en), 32'd0);

    // zero register on both sources; dest-0 pipeline frees port for r6 drain
    set_wb(1'b1, 3'd1, 16'h0121);
    set_lu(1'b1, 3'd6, 16'h0606);
    tick();
    set_wb(1'b1, 3'd0, 16'hFFFF);
    set_lu(1'b1, 3'd0, 16'hEEEE);
    tick();
    chk_wr("zero_drain", 3'd6, 16'h0606);
    set_wb(1'b1, 3'd0, 16'hFFFF);
    set_lu(1'b0, 3'd0, 16'h0);
    tick();
    chk("zero_en", 32'(bus.reg_write_en), 32'd0);
    chk("zero_rdy", 32'(bus.lu_ready), 32'd1);
    set_wb(1'b0, 3'd0, 16'h0);
    tick();
    chk("zero_no_entry", 32'(bus.reg_write_en), 32'd0);
    chk("zero_keep_data", 32'(bus.reg_write_data), 32'h0606);

    // reset with two entries queued
    set_wb(1'b1, 3'd1, 16'h0131);
    set_lu(1'b1, 3'd2, 16'h2222);
    tick();
    set_lu(1'b1, 3'd3, 16'h3333);
    tick();
    set_lu(1'b0, 3'd0, 16'h0);
    chk("rst2_full", 32'(bus.lu_ready), 32'd0);
    set_wb(1'b0, 3'd0, 16'h0);
    rst_n = 1'b0;
    #2;
    chk("rst2_en",    32'(bus.reg_write_en), 32'd0);
    chk("rst2_ready", 32'(bus.lu_ready), 32'd1);
    chk_pend("rst2_pend", 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_nowr1", 32'(bus.reg_write_en), 32'd0);
    tick();
    chk("rst2_nowr2", 32'(bus.reg_write_en), 32'd0);
    chk("rst2_dest",  32'(bus.reg_write_dest), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
